// File: rtl/vending_machine_change.sv
// vending_machine_change
//   Vending controller between the coin acceptor front end and the
//   dispenser/hopper drivers. It accepts 1/2/5 CNY coin pulses and vends
//   once the credit reaches PRICE. Overpayment is paid back as change. On
//   cancel or inactivity timeout the full credit is refunded. Change leaves
//   greedily, one hopper coin per ready handshake: 2 CNY first, then 1 CNY.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous reset, active-high
//   i_one_cny      1-cycle pulse: 1 CNY coin inserted
//   i_two_cny      1-cycle pulse: 2 CNY coin inserted
//   i_five_cny     1-cycle pulse: 5 CNY coin inserted
//   i_cancel       1-cycle pulse: refund the current credit (COLLECT only)
//   i_hopper_ready hopper takes the offered coin this cycle
//   o_done         1-cycle pulse: item vended
//   o_ret_one      valid: return one 1 CNY coin
//   o_ret_two      valid: return one 2 CNY coin
//   o_reject       1-cycle pulse: acceptor must eject the refused coin(s)
//   o_busy         high in VEND and RETURN, while coins are refused
//   o_credit       current credit in CNY
//
// Every output is a flop. The flops are loaded from the next-state values,
// so each output lines up with the state and change registers.
module vending_machine_change #(
  parameter  int PRICE       = 6,
  parameter  int TIMEOUT_CYC = 1000,
  parameter  int TO_W        = 10,
  localparam int CREDIT_W    = $clog2(PRICE + 5)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_one_cny,
  input  logic                i_two_cny,
  input  logic                i_five_cny,
  input  logic                i_cancel,
  input  logic                i_hopper_ready,
  output logic                o_done,
  output logic                o_ret_one,
  output logic                o_ret_two,
  output logic                o_reject,
  output logic                o_busy,
  output logic [CREDIT_W-1:0] o_credit
);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_VEND, S_RETURN} state_t;

  state_t              state_reg, state_next;
  logic [CREDIT_W-1:0] credit_reg, credit_next;
  logic [CREDIT_W-1:0] change_reg, change_next;
  logic [TO_W-1:0]     timer_reg, timer_next;
  logic                done_reg, done_next;
  logic                reject_reg, reject_next;
  logic                busy_reg, busy_next;
  logic                ret_one_reg, ret_one_next;
  logic                ret_two_reg, ret_two_next;

  logic                coin_any, coin_multi, timeout_hit;
  logic [CREDIT_W-1:0] coin_val, sum, change_dec;

  assign coin_any   = i_one_cny | i_two_cny | i_five_cny;
  assign coin_multi = (i_one_cny & i_two_cny) | (i_one_cny & i_five_cny) |
                      (i_two_cny & i_five_cny);
  // Several coins in one cycle: keep the highest value and eject the rest.
  assign coin_val   = i_five_cny ? CREDIT_W'(5) :
                      i_two_cny  ? CREDIT_W'(2) :
                      i_one_cny  ? CREDIT_W'(1) : '0;
  // Credit is below PRICE while coins are accepted, so sum <= PRICE+4 fits.
  assign sum        = credit_reg + coin_val;
  // A TIMEOUT_CYC of 0 disables the timeout. The guard keeps the -1 from mattering.
  assign timeout_hit = (TIMEOUT_CYC != 0) && (timer_reg == TO_W'(TIMEOUT_CYC - 1));
  assign change_dec  = (change_reg >= CREDIT_W'(2)) ? CREDIT_W'(2) : CREDIT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      credit_reg  <= '0;
      change_reg  <= '0;
      timer_reg   <= '0;
      done_reg    <= 1'b0;
      reject_reg  <= 1'b0;
      busy_reg    <= 1'b0;
      ret_one_reg <= 1'b0;
      ret_two_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      credit_reg  <= credit_next;
      change_reg  <= change_next;
      timer_reg   <= timer_next;
      done_reg    <= done_next;
      reject_reg  <= reject_next;
      busy_reg    <= busy_next;
      ret_one_reg <= ret_one_next;
      ret_two_reg <= ret_two_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    credit_next = credit_reg;
    change_next = change_reg;
    timer_next  = timer_reg;
    done_next   = 1'b0;
    reject_next = 1'b0;

    case (state_reg)
      S_IDLE, S_COLLECT: begin
        reject_next = coin_multi;
        if (coin_any) begin
          // The coin is applied before a cancel in the same cycle. A vend wins
          // over the refund.
          timer_next  = '0;
          credit_next = sum;
          state_next  = S_COLLECT;
          if (sum >= CREDIT_W'(PRICE)) begin
            change_next = sum - CREDIT_W'(PRICE);
            state_next  = S_VEND;
          end else if (state_reg == S_COLLECT && i_cancel) begin
            change_next = sum;
            credit_next = '0;
            state_next  = S_RETURN;
          end
        end else if (state_reg == S_COLLECT) begin
          if (i_cancel || timeout_hit) begin
            change_next = credit_reg;
            credit_next = '0;
            timer_next  = '0;
            state_next  = S_RETURN;
          end else begin
            timer_next = timer_reg + TO_W'(1);
          end
        end
      end
      S_VEND: begin
        reject_next = coin_any;
        done_next   = 1'b1;
        credit_next = '0;
        state_next  = (change_reg != '0) ? S_RETURN : S_IDLE;
      end
      S_RETURN: begin
        reject_next = coin_any;
        // A valid is always offered in RETURN, so ready alone completes a handshake.
        if (i_hopper_ready) begin
          change_next = change_reg - change_dec;
          if (change_reg == change_dec) state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase

    busy_next    = (state_next == S_VEND) || (state_next == S_RETURN);
    ret_two_next = (state_next == S_RETURN) && (change_next >= CREDIT_W'(2));
    ret_one_next = (state_next == S_RETURN) && (change_next == CREDIT_W'(1));
  end

  assign o_done    = done_reg;
  assign o_reject  = reject_reg;
  assign o_busy    = busy_reg;
  assign o_ret_one = ret_one_reg;
  assign o_ret_two = ret_two_reg;
  assign o_credit  = credit_reg;

endmodule

// File: tb/tb_vending_machine_change.sv
module tb_vending_machine_change;

  localparam int PRICE    = 6;
  localparam int CREDIT_W = $clog2(PRICE + 5);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_one_cny = 1'b0, i_two_cny = 1'b0, i_five_cny = 1'b0;
  logic i_cancel = 1'b0, i_hopper_ready = 1'b1;
  logic o_done, o_ret_one, o_ret_two, o_reject, o_busy;
  logic [CREDIT_W-1:0] o_credit;

  int n_compared   = 0;
  int n_mismatched = 0;
  int done_cnt = 0, two_cnt = 0, one_cnt = 0, both_cnt = 0, reject_cnt = 0;

  vending_machine_change #(.PRICE(PRICE), .TIMEOUT_CYC(8), .TO_W(4)) dut (
    .clk(clk), .rst(rst),
    .i_one_cny(i_one_cny), .i_two_cny(i_two_cny), .i_five_cny(i_five_cny),
    .i_cancel(i_cancel), .i_hopper_ready(i_hopper_ready),
    .o_done(o_done), .o_ret_one(o_ret_one), .o_ret_two(o_ret_two),
    .o_reject(o_reject), .o_busy(o_busy), .o_credit(o_credit)
  );

  always #5 clk = ~clk;

  // Event counters, sampled mid-cycle while inputs and outputs are stable.
  always @(negedge clk) begin
    if (!rst) begin
      if (o_done) done_cnt++;
      if (o_reject) reject_cnt++;
      if (o_ret_two && i_hopper_ready) two_cnt++;
      if (o_ret_one && i_hopper_ready) one_cnt++;
      if (o_ret_one && o_ret_two) both_cnt++;
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic coin(input int v);
    i_one_cny  = (v == 1);
    i_two_cny  = (v == 2);
    i_five_cny = (v == 5);
    tick();
    i_one_cny = 0; i_two_cny = 0; i_five_cny = 0;
  endtask

  task automatic clear_counts();
    done_cnt = 0; two_cnt = 0; one_cnt = 0; reject_cnt = 0;
  endtask

  initial begin
    // Reset state
    tick(3);
    check("rst_done",   o_done,   0);
    check("rst_busy",   o_busy,   0);
    check("rst_credit", o_credit, 0);
    check("rst_ret",    {o_ret_one, o_ret_two}, 0);
    rst = 0;
    tick();

    // 1) 5 + 1 = PRICE: vend with no change
    clear_counts();
    coin(5);
    check("t1_credit5", o_credit, 5);
    coin(1);
    check("t1_vend_busy",   o_busy,   1);
    check("t1_vend_credit", o_credit, 6);
    tick();
    check("t1_done_pulse", o_done,   1);
    check("t1_credit0",    o_credit, 0);
    tick(4);
    check("t1_done_cnt", done_cnt, 1);
    check("t1_change",   two_cnt + one_cnt, 0);
    check("t1_idle",     o_busy, 0);

    // 2) 5 + 5: change 4 paid as two 2 CNY coins
    clear_counts();
    coin(5); coin(5);
    tick(6);
    check("t2_done_cnt", done_cnt, 1);
    check("t2_two_cnt",  two_cnt,  2);
    check("t2_one_cnt",  one_cnt,  0);
    check("t2_idle",     o_busy,   0);

    // 3) 2 + 1 then cancel: refund 3 as 2 + 1
    clear_counts();
    coin(2); coin(1);
    check("t3_credit3", o_credit, 3);
    i_cancel = 1; tick(); i_cancel = 0;
    check("t3_credit0", o_credit, 0);
    tick(5);
    check("t3_done_cnt", done_cnt, 0);
    check("t3_two_cnt",  two_cnt,  1);
    check("t3_one_cnt",  one_cnt,  1);

    // 4) 2 and 5 in the same cycle: keep 5, reject the other
    clear_counts();
    i_two_cny = 1; i_five_cny = 1; tick(); i_two_cny = 0; i_five_cny = 0;
    check("t4_credit5", o_credit, 5);
    check("t4_reject",  o_reject, 1);
    tick();
    check("t4_reject_end", o_reject, 0);
    i_cancel = 1; tick(); i_cancel = 0;
    tick(6);
    check("t4_refund", 2 * two_cnt + one_cnt, 5);
    check("t4_reject_cnt", reject_cnt, 1);

    // 5) Hopper back-pressure holds the valid until ready
    clear_counts();
    i_hopper_ready = 0;
    coin(5); coin(5);
    tick();
    for (int k = 0; k < 5; k++) begin
      check("t5_hold_two", o_ret_two, 1);
      tick();
    end
    check("t5_no_handshake", two_cnt, 0);
    i_hopper_ready = 1;
    tick(5);
    check("t5_two_cnt", two_cnt, 2);
    check("t5_idle",    o_busy,  0);

    // 6) Timeout after 8 idle cycles in COLLECT, then coin refused in RETURN
    clear_counts();
    i_hopper_ready = 0;
    coin(1);
    tick(7);
    check("t6_before_to_busy",   o_busy,   0);
    check("t6_before_to_credit", o_credit, 1);
    tick();
    check("t6_ret_one", o_ret_one, 1);
    check("t6_busy",    o_busy,    1);
    coin(2);
    check("t6_reject",    o_reject, 1);
    check("t6_credit0",   o_credit, 0);
    i_hopper_ready = 1;
    tick(4);
    check("t6_one_cnt", one_cnt, 1);
    check("t6_two_cnt", two_cnt, 0);
    check("t6_idle",    o_busy,  0);

    // 7) Asynchronous reset during RETURN drops the pending change
    clear_counts();
    i_hopper_ready = 0;
    coin(5); coin(5);
    tick();
    check("t7_in_return", o_ret_two, 1);
    #2 rst = 1;
    #1;
    check("t7_async_ret",  {o_ret_one, o_ret_two}, 0);
    check("t7_async_busy", o_busy, 0);
    tick(2);
    rst = 0;
    i_hopper_ready = 1;
    tick(4);
    check("t7_after_busy", o_busy,  0);
    check("t7_lost_change", two_cnt + one_cnt, 0);

    check("never_both_valid", both_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
